// File: rtl/ultrasonic_multi_ranger_pkg.sv
// Shared types and helpers for the multi-channel ultrasonic ranger.
// Difference arithmetic is done in DIFF_W bits so CNT_W-wide distances never wrap.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT,
        MEAS,
        RESULT,
        HOLD
    } state_t;

    localparam int DIFF_W = 32;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ultrasonic_multi_ranger_echo_conditioner.sv
// Per-channel echo conditioning: 2-flop synchroniser, plus a stability filter
// when ECHO_GLITCH_FILTER_EN is defined (both edges delayed by FILT_CYCLES).
module echo_conditioner #(
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic echo_raw,
    output logic echo_clean
);

`ifdef ECHO_GLITCH_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif
    localparam int FILT_LEN = FILT_EN ? FILT_CYCLES : 0;

    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= echo_raw;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        if (FILT_LEN > 0) begin : g_filt
            localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
            logic           filt_reg;
            logic [FCW-1:0] stable_reg;

            // Level flips only after FILT_LEN consecutive cycles of disagreement.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    filt_reg   <= 1'b0;
                    stable_reg <= '0;
                end else if (sync2_reg == filt_reg) begin
                    stable_reg <= '0;
                end else if (stable_reg == FCW'(FILT_LEN - 1)) begin
                    filt_reg   <= sync2_reg;
                    stable_reg <= '0;
                end else begin
                    stable_reg <= stable_reg + 1'b1;
                end
            end

            assign echo_clean = filt_reg;
        end else begin : g_nofilt
            assign echo_clean = sync2_reg;
        end
    endgenerate

endmodule

// File: rtl/ultrasonic_multi_ranger.sv
// Round-robin multi-sensor ultrasonic ranger with timeouts and per-channel motion debounce.
// Optional echo glitch filter enabled by defining ECHO_GLITCH_FILTER_EN.
module ultrasonic_multi_ranger
    import ultrasonic_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16,
    parameter int TRIG_CYCLES    = 1000,
    parameter int ECHO_WAIT      = 50000,
    parameter int MAX_COUNT      = 60000,
    parameter int HOLDOFF_CYCLES = 6000,
    parameter int THRESHOLD      = 100,
    parameter int HITS           = 2,
    parameter int FILT_CYCLES    = 4,
    localparam int CH_W          = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trigger,
    output logic              dist_valid,
    output logic [CH_W-1:0]   dist_ch,
    output logic [CNT_W-1:0]  dist_value,
    output logic              dist_timeout,
    output logic [NUM_CH-1:0] motion,
    output logic              busy
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(MAX_COUNT - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [3:0]       HITS_V    = 4'(HITS);

    logic [NUM_CH-1:0] echo_sync;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cond
            echo_conditioner #(
                .FILT_CYCLES(FILT_CYCLES)
            ) u_cond (
                .clk       (clk),
                .rst_n     (rst_n),
                .echo_raw  (echo[gi]),
                .echo_clean(echo_sync[gi])
            );
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [CH_W-1:0]   ch_reg, ch_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              timeout_reg, timeout_next;
    logic              echo_act;
    logic              result_load;
    logic [NUM_CH-1:0] trig_next;

    assign echo_act    = echo_sync[ch_reg];
    assign result_load = (state_next == RESULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ch_reg      <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ch_reg      <= ch_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    // One counter serves as trigger timer, wait timer, echo width and holdoff timer.
    always_comb begin
        state_next   = state_reg;
        ch_next      = ch_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = TRIG;
                    cnt_next   = '0;
                end
            end
            TRIG: begin
                if (cnt_reg == TRIG_LAST) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT: begin
                if (echo_act) begin
                    state_next   = MEAS;
                    cnt_next     = CNT_W'(1);
                    timeout_next = 1'b0;
                end else if (cnt_reg == WAIT_LAST) begin
                    state_next   = RESULT;
                    cnt_next     = COUNT_MAX;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            MEAS: begin
                if (!echo_act) begin
                    state_next = RESULT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == MEAS_LAST) begin
                        state_next   = RESULT;
                        timeout_next = 1'b1;
                    end
                end
            end
            RESULT: begin
                state_next = HOLD;
                cnt_next   = '0;
            end
            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    cnt_next   = '0;
                    ch_next    = (ch_reg == CH_LAST) ? '0 : ch_reg + 1'b1;
                    state_next = enable ? TRIG : IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        trig_next = '0;
        if (state_next == TRIG) begin
            trig_next[ch_next] = 1'b1;
        end
    end

    logic [NUM_CH-1:0] trigger_reg;
    logic              busy_reg;
    logic              dist_valid_reg;
    logic [CH_W-1:0]   dist_ch_reg;
    logic [CNT_W-1:0]  dist_value_reg;
    logic              dist_timeout_reg;

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger_reg      <= '0;
            busy_reg         <= 1'b0;
            dist_valid_reg   <= 1'b0;
            dist_ch_reg      <= '0;
            dist_value_reg   <= '0;
            dist_timeout_reg <= 1'b0;
        end else begin
            trigger_reg    <= trig_next;
            busy_reg       <= (state_next != IDLE);
            dist_valid_reg <= result_load;
            if (result_load) begin
                dist_ch_reg      <= ch_reg;
                dist_value_reg   <= cnt_next;
                dist_timeout_reg <= timeout_next;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_motion
            logic [CNT_W-1:0] prev_dist_reg;
            logic             prev_valid_reg;
            logic [3:0]       hit_reg;
            logic [3:0]       hit_next;
            logic             motion_reg;
            logic             upd;
            logic             over;

            assign upd  = result_load && !timeout_next && (ch_reg == CH_W'(gi));
            assign over = abs_diff(DIFF_W'(cnt_next), DIFF_W'(prev_dist_reg)) > DIFF_W'(THRESHOLD);
            assign hit_next = !over ? 4'd0 :
                              (hit_reg == HITS_V) ? HITS_V : hit_reg + 4'd1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_dist_reg  <= '0;
                    prev_valid_reg <= 1'b0;
                    hit_reg        <= '0;
                    motion_reg     <= 1'b0;
                end else if (upd) begin
                    prev_dist_reg <= cnt_next;
                    if (!prev_valid_reg) begin
                        prev_valid_reg <= 1'b1;
                    end else begin
                        hit_reg    <= hit_next;
                        motion_reg <= (hit_next == HITS_V);
                    end
                end
            end

            assign motion[gi] = motion_reg;
        end
    endgenerate

    assign trigger      = trigger_reg;
    assign busy         = busy_reg;
    assign dist_valid   = dist_valid_reg;
    assign dist_ch      = dist_ch_reg;
    assign dist_value   = dist_value_reg;
    assign dist_timeout = dist_timeout_reg;

endmodule

// File: doc/ultrasonic_multi_ranger.md
Name:
ultrasonic_multi_ranger

Overview:
- Parametrised, multi-channel successor to the team's single-sensor ultrasonic motion detector.
- Fires NUM_CH HC-SR04-class sensors in round-robin so that only one sensor pings at a time, which avoids crosstalk.
- Per ping: measures the echo width with no-echo and echo-stuck timeouts, publishes each result on a one-cycle valid strobe, and keeps a per-channel debounced motion flag.
- Sits between the sensor pins and the system event and alarm logic.

Parameters:
- NUM_CH, 4: number of sensors; must be ≥1.
- CNT_W, 16: width of distance and timer counters.
- TRIG_CYCLES, 1000: trigger pulse width in clk cycles (10 µs at 100 MHz).
- ECHO_WAIT, 50000: maximum cycles from trigger fall to echo rise before a timeout.
- MAX_COUNT, 60000: echo-width saturation; reaching it is a timeout. Must be < 2^CNT_W.
- HOLDOFF_CYCLES, 6000: idle gap after each ping before the next channel fires.
- THRESHOLD, 100: motion if |distance − previous distance| > THRESHOLD.
- HITS, 2: consecutive over-threshold results needed to assert motion; 1..15.
- FILT_CYCLES, 4: echo stability requirement; used only with ECHO_GLITCH_FILTER_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run the round-robin scan.
- echo  in  NUM_CH  raw echo pins; asynchronous.
- trigger  out  NUM_CH  trigger pins; at most one bit high at any time.
- dist_valid  out  1  one-cycle result strobe.
- dist_ch  out  CH_W  channel of the current result (CH_W = max(1, clog2(NUM_CH))).
- dist_value  out  CNT_W  echo width in cycles; equals MAX_COUNT on timeout.
- dist_timeout  out  1  qualifies dist_valid: no echo, or echo stuck high.
- motion  out  NUM_CH  per-channel motion level.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, FSM in IDLE, channel pointer 0.
  - Per-channel prev_dist, prev_valid and hit counter cleared.
  - Reset mid-ping aborts immediately and drops trigger.
- Echo path: 2-flop synchroniser per channel. Only the active channel's synchronised echo is used; all other channels are ignored.
- FSM states: IDLE, TRIG, WAIT, MEAS, RESULT, HOLD.
  - IDLE: when enable=1, go to TRIG. Channel pointer is unchanged.
  - TRIG: trigger[ch]=1 for exactly TRIG_CYCLES cycles, then go to WAIT with the timer cleared.
  - WAIT:
    - Synchronised echo high → MEAS, count=1.
    - Timer reaching ECHO_WAIT → RESULT with timeout.
    - Echo already high on entry counts as a rising edge.
  - MEAS: count increments on each cycle that echo is high.
    - Echo sampled low → RESULT, value=count.
    - Count reaching MAX_COUNT → RESULT with timeout; the echo is not waited on.
  - RESULT (1 cycle):
    - dist_valid=1; dist_ch=ch; dist_value = count, or MAX_COUNT on timeout; dist_timeout set accordingly.
    - dist_ch, dist_value and dist_timeout hold until the next RESULT.
  - HOLD: HOLDOFF_CYCLES cycles.
    - Then ch = ch+1, wrapping from NUM_CH−1 to 0.
    - Next state is TRIG if enable=1, else IDLE.
- Enable deasserted mid-ping: the current ping completes through HOLD, then the FSM goes to IDLE. No truncated results.
- Latency: dist_valid rises 3 clk after the raw echo falls (2 sync + 1). Result width = synchronised high cycles (±1 cycle jitter against raw).
- Motion update, performed in RESULT for channel ch:
  - Timeout: prev_dist, hit counter and motion are untouched.
  - First valid result (prev_valid=0): store prev_dist, set prev_valid, no comparison.
  - Otherwise:
    - Compute the difference in CNT_W+1 bits, so there is no wrap.
    - |d−prev| > THRESHOLD: hit counter increments, saturating at HITS. Equal to THRESHOLD is not a hit.
    - Else: hit counter = 0.
    - In both cases prev_dist = d.
  - motion[ch] = (hit counter == HITS), registered, and updates in the same cycle as dist_valid.

Optional Feature:
- ECHO_GLITCH_FILTER_EN defined:
  - Each synchronised echo passes a per-channel filter.
  - The filtered level changes only after the input has been stable for FILT_CYCLES consecutive cycles.
  - Pulses shorter than FILT_CYCLES are ignored.
  - Width is preserved because both edges are delayed equally; latency becomes 3+FILT_CYCLES.
- Undefined: no filter; the 2-flop synchroniser output feeds the FSM directly.

Decomposition:
- Package ultrasonic_pkg:
  - FSM state enum: IDLE, TRIG, WAIT, MEAS, RESULT, HOLD.
  - Function computing CH_W from NUM_CH.
  - Absolute-difference helper function.
- Sub-module echo_conditioner, instantiated once per channel: 2-flop synchroniser plus the optional glitch filter.

Test Plan:
All scenarios use NUM_CH=2, TRIG_CYCLES=10, ECHO_WAIT=50, MAX_COUNT=200, HOLDOFF_CYCLES=20, THRESHOLD=20, HITS=2, unless stated otherwise.
- Basic ping: enable=1; ch0 echo rises 5 cycles after trigger falls, high 80 cycles → trigger[0] exactly 10 cycles wide; dist_valid with dist_ch=0, dist_value=80, dist_timeout=0; then trigger[1] fires after 20 HOLD cycles.
- No echo on ch1 → after 50 cycles in WAIT, dist_valid with dist_value=200, dist_timeout=1; motion[1] unchanged; scan returns to ch0.
- Stuck echo: ch0 echo held high → dist_value=200, dist_timeout=1 at count 200, without waiting for the echo to fall.
- Motion debounce on ch0, widths 80, 120, 150, 151, 100, ch1 silent:
  - 80 stores the baseline.
  - 120 gives hit 1; motion[0]=0.
  - 150 gives hit 2; motion[0]=1.
  - 151 (diff 1) clears the hit counter; motion[0]=0.
  - 100 (diff 51) gives hit 1; motion[0]=0.
  - A diff of exactly 20 is not a hit.
- Enable dropped during MEAS → the result is still delivered, HOLD completes, FSM goes to IDLE with busy=0, and the next ping uses the next channel once enable is reasserted.
- rst_n pulsed low mid-TRIG → trigger=0 immediately; all outputs 0; the first result after release only sets the baseline. With ECHO_GLITCH_FILTER_EN: a 3-cycle echo glitch during WAIT is ignored.
